ring_sequence_monitor: RTL

RING_SEQUENCE_MONITOR -- requirements
Module: ring_sequence_monitor

---
 rtl/ring_sequence_monitor_pkg.sv | 20 ++
 rtl/ring_code_decode.sv | 38 +++
 rtl/ring_sequence_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ring_sequence_monitor_pkg.sv
// Shared types and constants for the ring/Johnson counter sequence monitor.
package ring_sequence_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    PEND   = 2'd1,
    LOCKED = 2'd2
  } rsm_state_e;

  localparam int unsigned ERR_COUNT_MAX = 255;
  localparam int unsigned RUN_W         = 4;

  function automatic int unsigned code_len(
    input int unsigned width,
    input bit          johnson
  );
    return johnson ? 2 * width : width;
  endfunction

endpackage

// File: rtl/ring_code_decode.sv
// Combinational legality check, position decode and successor for one code.
module ring_code_decode
  import ring_sequence_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int JOHNSON = 0,
  localparam int IW = $clog2(code_len(WIDTH, JOHNSON != 0))
) (
  input  logic [WIDTH-1:0] q,
  output logic             legal,
  output logic [IW-1:0]    index,
  output logic [WIDTH-1:0] successor
);

  if (JOHNSON == 0) begin : g_ring
    assign legal     = $onehot(q);
    assign successor = {q[WIDTH-2:0], q[WIDTH-1]};

    always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (q[i]) index = IW'(i);
      end
    end
  end else begin : g_john
    logic [WIDTH-1:0] w_thr;
    logic [IW-1:0]    w_pop;

    // Legal codes are a low run of ones, or its complement.
    assign w_thr     = q[WIDTH-1] ? ~q : q;
    assign legal     = ((w_thr & (w_thr + WIDTH'(1))) == '0);
    assign w_pop     = IW'($countones(q));
    assign successor = {q[WIDTH-2:0], ~q[WIDTH-1]};
    assign index     = q[WIDTH-1] ? (IW'(2 * WIDTH) - w_pop)
                                  : w_pop;
  end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Tracks a ring or Johnson counter, locks after LOCK_CNT good steps.
// Define RING_SEQUENCE_MONITOR_ERR_COUNT_EN to build the error counter.
module ring_sequence_monitor
  import ring_sequence_monitor_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int JOHNSON  = 0,
  parameter int LOCK_CNT = 2,
  localparam int IW = $clog2(code_len(WIDTH, JOHNSON != 0))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             q_valid,
  input  logic             clear_err,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [7:0]       err_count
);

  logic             w_legal;
  logic [IW-1:0]    w_index;
  logic [WIDTH-1:0] w_succ;
  logic             w_hit;
  logic             w_detect;
  logic [RUN_W-1:0] w_run_inc;

  rsm_state_e       r_state;
  logic [WIDTH-1:0] r_expect;
  logic [RUN_W-1:0] r_run;
  logic [IW-1:0]    r_index;
  logic             r_index_valid;
  logic             r_seq_err;

  ring_code_decode #(
    .WIDTH   (WIDTH),
    .JOHNSON (JOHNSON)
  ) u_dec (
    .q         (q),
    .legal     (w_legal),
    .index     (w_index),
    .successor (w_succ)
  );

  // r_expect always holds a legal code, so a hit implies legality.
  assign w_hit     = (q == r_expect);
  assign w_run_inc = r_run + RUN_W'(1);
  assign w_detect  = q_valid && (r_state == LOCKED) && !w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HUNT;
      r_expect      <= '0;
      r_run         <= '0;
      r_index       <= '0;
      r_index_valid <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_index_valid <= 1'b0;
      r_seq_err     <= 1'b0;
      if (q_valid) begin
        if (w_legal) begin
          r_index       <= w_index;
          r_index_valid <= 1'b1;
          r_expect      <= w_succ;
        end
        unique case (r_state)
          HUNT: begin
            if (w_legal) begin
              r_state <= PEND;
              r_run   <= '0;
            end
          end
          PEND: begin
            if (!w_legal) begin
              r_state <= HUNT;
              r_run   <= '0;
            end else if (w_hit) begin
              r_run <= w_run_inc;
              if (w_run_inc == RUN_W'(LOCK_CNT))
                r_state <= LOCKED;
            end else begin
              r_run <= '0;
            end
          end
          LOCKED: begin
            if (!w_hit) begin
              r_seq_err <= 1'b1;
              r_run     <= '0;
              r_state   <= w_legal ? PEND : HUNT;
            end
          end
          default: begin
            r_state <= HUNT;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  assign index       = r_index;
  assign index_valid = r_index_valid;
  assign seq_err     = r_seq_err;
  assign locked      = (r_state == LOCKED);

`ifdef RING_SEQUENCE_MONITOR_ERR_COUNT_EN
  logic [7:0] r_err_count;

  // An error and a clear in the same cycle leave exactly that error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (w_detect) begin
      if (clear_err)
        r_err_count <= 8'd1;
      else if (r_err_count != 8'(ERR_COUNT_MAX))
        r_err_count <= r_err_count + 8'd1;
    end else if (clear_err) begin
      r_err_count <= '0;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err;

  assign w_unused_err = clear_err ^ w_detect;
  assign err_count    = '0;
`endif

endmodule
